// File: rtl/phy_tx.sv
// Two-lane serializer: trains with comma slots after reset, then streams 32-bit
// words MSB first on a shared 32-cycle slot grid, filling idle slots with commas.
module phy_tx #(
    parameter int TRAIN_WORDS = 1
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] data_in0,
    input  logic        valid_in0,
    input  logic [31:0] data_in1,
    input  logic        valid_in1,
    output logic        ready_out,
    output logic        data_out0,
    output logic        data_out1,
    output logic        active
);

    localparam logic [31:0] COMMA_SLOT = 32'hBCBC_BCBC;
    localparam logic [3:0]  TRAIN_LAST = 4'(TRAIN_WORDS - 1);

    typedef enum logic {TRAIN, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  train_cnt_q, train_cnt_d;
    logic [31:0] sh0_q, sh0_d;
    logic [31:0] sh1_q, sh1_d;
    logic        dout0_q, dout0_d;
    logic        dout1_q, dout1_d;
    logic        last_bit;

    assign last_bit = (bit_cnt_q == 5'd31);

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        ready_out   = 1'b0;
        bit_cnt_d   = bit_cnt_q + 5'd1;
        dout0_d     = sh0_q[31];
        dout1_d     = sh1_q[31];
        sh0_d       = {sh0_q[30:0], 1'b0};
        sh1_d       = {sh1_q[30:0], 1'b0};

        case (state_q)
            TRAIN: begin
                if (last_bit) begin
                    // The final training edge already belongs to the data stream.
                    if (train_cnt_q == TRAIN_LAST) begin
                        state_d   = ACTIVE;
                        ready_out = reset;
                    end else begin
                        train_cnt_d = train_cnt_q + 4'd1;
                    end
                end
            end
            ACTIVE: ready_out = last_bit && reset;
            default: state_d = TRAIN;
        endcase

        if (last_bit) begin
            sh0_d = (ready_out && valid_in0) ? data_in0 : COMMA_SLOT;
            sh1_d = (ready_out && valid_in1) ? data_in1 : COMMA_SLOT;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q     <= TRAIN;
            bit_cnt_q   <= 5'd0;
            train_cnt_q <= 4'd0;
            sh0_q       <= COMMA_SLOT;
            sh1_q       <= COMMA_SLOT;
            dout0_q     <= 1'b0;
            dout1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            train_cnt_q <= train_cnt_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            dout0_q     <= dout0_d;
            dout1_q     <= dout1_d;
        end
    end

    assign data_out0 = dout0_q;
    assign data_out1 = dout1_q;
    assign active    = (state_q == ACTIVE);

endmodule
